// File: rtl/cache_lookup_ctrl.sv
// Set-associative tag/valid lookup controller that initiates the LRU replacement handshake.
// One access in flight: classify hit / fill-empty / replace, run one LRU transaction, apply the victim.
module cache_lookup_ctrl #(
    parameter  int way                = 4,
    parameter  int block_size_byte    = 16,
    parameter  int cache_size_byte    = 32768,
    parameter  int addr_width         = 32,
    parameter  int lru_timeout        = 64,
    localparam int block_offset_index = $clog2(block_size_byte),
    localparam int set                = cache_size_byte / (block_size_byte * way),
    localparam int set_index          = $clog2(set),
    localparam int tag_width          = addr_width - set_index - block_offset_index
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [4:0]            resp_way,
    output logic                  resp_evict,
    output logic [tag_width-1:0]  resp_evict_tag,
    output logic                  resp_error,
    output logic                  start,
    output logic [set_index-1:0]  index,
    output logic                  found_in_cache,
    output logic                  updated_cache,
    output logic                  replace,
    output logic [4:0]            way_index,
    input  logic                  update_lru,
    input  logic                  block_replace,
    input  logic [4:0]            replace_index
);
    localparam int               WAY_W     = (way > 1) ? $clog2(way) : 1;
    localparam int               CNT_W     = $clog2(lru_timeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(lru_timeout - 1);
    localparam logic [4:0]       WAY_LIMIT = 5'(way);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_LRU_REQ  = 3'd2,
        ST_LRU_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_HIT  = 2'd0,
        CLS_FILL = 2'd1,
        CLS_REPL = 2'd2
    } cls_t;

    function automatic logic [WAY_W-1:0] first_set(input logic [way-1:0] vec);
        logic [WAY_W-1:0] pos;
        pos = '0;
        for (int w = way - 1; w >= 0; w--) begin
            if (vec[w]) begin
                pos = WAY_W'(w);
            end
        end
        return pos;
    endfunction

    state_t               state_r, state_next_s;
    cls_t                 cls_r, cls_next_s;
    logic [WAY_W-1:0]     way_sel_r, way_next_s;
    logic [tag_width-1:0] lat_tag_r;
    logic [set_index-1:0] lat_index_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [way-1:0]       valid_r [set];
    logic [tag_width-1:0] tag_mem_r [set][way];
    logic [way-1:0]       hit_vec_s, empty_vec_s;
    logic                 timeout_s, wr_en_s, fin_hit_s, fin_err_s, fin_evict_s;
    logic [WAY_W-1:0]     wr_way_s;
    logic [4:0]           fin_way_s;
    logic [tag_width-1:0] evict_tag_s;
    logic                 unused_offset_s;

    // Byte offset does not take part in tag/valid lookup.
    assign unused_offset_s = ^req_addr[block_offset_index-1:0];

    // Parallel tag compare over the latched set and classification of the access.
    always_comb begin
        hit_vec_s   = '0;
        empty_vec_s = '0;
        cls_next_s  = cls_r;
        way_next_s  = way_sel_r;
        for (int w = 0; w < way; w++) begin
            hit_vec_s[w]   = valid_r[lat_index_r][w] && (tag_mem_r[lat_index_r][w] == lat_tag_r);
            empty_vec_s[w] = !valid_r[lat_index_r][w];
        end
        if (state_r == ST_LOOKUP) begin
            if (|hit_vec_s) begin
                cls_next_s = CLS_HIT;
                way_next_s = first_set(hit_vec_s);
            end else if (|empty_vec_s) begin
                cls_next_s = CLS_FILL;
                way_next_s = first_set(empty_vec_s);
            end else begin
                cls_next_s = CLS_REPL;
                way_next_s = '0;
            end
        end else begin
            cls_next_s = cls_r;
            way_next_s = way_sel_r;
        end
    end

    // Outcome of the LRU transaction; an out-of-range or missing victim is an error.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_way_s    = way_sel_r;
        fin_hit_s   = 1'b0;
        fin_err_s   = 1'b0;
        fin_evict_s = 1'b0;
        fin_way_s   = 5'd0;
        evict_tag_s = '0;
        timeout_s   = (state_r == ST_LRU_WAIT) && (cnt_r == CNT_LAST);
        if ((state_r == ST_LRU_WAIT) && update_lru) begin
            case (cls_r)
                CLS_HIT: begin
                    fin_hit_s = 1'b1;
                    fin_way_s = 5'(way_sel_r);
                end
                CLS_FILL: begin
                    wr_en_s   = 1'b1;
                    fin_way_s = 5'(way_sel_r);
                end
                CLS_REPL: begin
                    if (block_replace && (replace_index < WAY_LIMIT)) begin
                        wr_en_s     = 1'b1;
                        wr_way_s    = replace_index[WAY_W-1:0];
                        fin_evict_s = 1'b1;
                        fin_way_s   = replace_index;
                        evict_tag_s = tag_mem_r[lat_index_r][replace_index[WAY_W-1:0]];
                    end else begin
                        fin_err_s = 1'b1;
                    end
                end
                default: fin_err_s = 1'b1;
            endcase
        end else if (timeout_s) begin
            fin_err_s = 1'b1;
        end else begin
            fin_err_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:     state_next_s = req_valid ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP:   state_next_s = ST_LRU_REQ;
            ST_LRU_REQ:  state_next_s = ST_LRU_WAIT;
            ST_LRU_WAIT: state_next_s = (update_lru || timeout_s) ? ST_RESP : ST_LRU_WAIT;
            ST_RESP:     state_next_s = resp_ready ? ST_IDLE : ST_RESP;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // State, request latch, classification and LRU wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cls_r       <= CLS_HIT;
            way_sel_r   <= '0;
            lat_tag_r   <= '0;
            lat_index_r <= '0;
            cnt_r       <= '0;
        end else begin
            state_r   <= state_next_s;
            cls_r     <= cls_next_s;
            way_sel_r <= way_next_s;
            cnt_r     <= (state_r == ST_LRU_WAIT) ? cnt_r + CNT_W'(1) : '0;
            if ((state_r == ST_IDLE) && req_valid) begin
                lat_tag_r   <= req_addr[addr_width-1 -: tag_width];
                lat_index_r <= req_addr[block_offset_index +: set_index];
            end
        end
    end

    // Valid bits: cleared on reset, set when a line is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < set; s++) begin
                valid_r[s] <= '0;
            end
        end else if (wr_en_s) begin
            valid_r[lat_index_r][wr_way_s] <= 1'b1;
        end
    end

    // Tag storage; contents are qualified by the valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_mem_r[lat_index_r][wr_way_s] <= lat_tag_r;
        end
    end

    // Registered handshake and response outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready      <= 1'b1;
            start          <= 1'b0;
            index          <= '0;
            found_in_cache <= 1'b0;
            updated_cache  <= 1'b0;
            replace        <= 1'b0;
            way_index      <= 5'd0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= 5'd0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
            resp_error     <= 1'b0;
        end else begin
            req_ready  <= (state_next_s == ST_IDLE);
            start      <= (state_next_s == ST_LRU_REQ);
            resp_valid <= (state_next_s == ST_RESP);
            if ((state_next_s == ST_LRU_REQ) || (state_next_s == ST_LRU_WAIT)) begin
                index          <= lat_index_r;
                found_in_cache <= (cls_next_s == CLS_HIT);
                updated_cache  <= (cls_next_s == CLS_FILL);
                replace        <= (cls_next_s == CLS_REPL);
                way_index      <= (cls_next_s == CLS_REPL) ? 5'd0 : 5'(way_next_s) + 5'd1;
            end else begin
                index          <= '0;
                found_in_cache <= 1'b0;
                updated_cache  <= 1'b0;
                replace        <= 1'b0;
                way_index      <= 5'd0;
            end
            if ((state_r == ST_LRU_WAIT) && (state_next_s == ST_RESP)) begin
                resp_hit       <= fin_hit_s;
                resp_way       <= fin_way_s;
                resp_evict     <= fin_evict_s;
                resp_evict_tag <= evict_tag_s;
                resp_error     <= fin_err_s;
            end else if ((state_r == ST_RESP) && resp_ready) begin
                resp_hit       <= 1'b0;
                resp_way       <= 5'd0;
                resp_evict     <= 1'b0;
                resp_evict_tag <= '0;
                resp_error     <= 1'b0;
            end else begin
                resp_hit <= resp_hit;
            end
        end
    end
endmodule

// File: doc/cache_lookup_ctrl.md
Name: cache_lookup_ctrl

Overview:
- Set-associative tag/valid lookup controller; initiator side of the LRU replacement handshake (start, found_in_cache, updated_cache, replace, way_index → update_lru, block_replace, replace_index).
- Accepts one core access at a time, compares tags across all ways and classifies the access as hit, fill-empty or replace.
- Issues exactly one LRU transaction per access, applies the returned victim to its tag array, and reports the result to the core.
- Sits between the core request port and the LRU block, one instance per core cache.

Parameters:
- way, 4, associativity (power of 2, ≤16)
- block_size_byte, 16, line size in bytes
- cache_size_byte, 32768, total capacity in bytes
- addr_width, 32, address width
- lru_timeout, 64, max cycles to wait for update_lru
- derived (not overridable): block_offset_index = log2(block_size_byte); set = cache_size_byte/(block_size_byte*way); set_index = log2(set); tag_width = addr_width - set_index - block_offset_index

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core access request
- req_ready  out  1  controller idle, can accept a request
- req_addr  in  addr_width  byte address
- resp_valid  out  1  result available
- resp_ready  in  1  core accepts result
- resp_hit  out  1  access hit
- resp_way  out  5  0-based way used
- resp_evict  out  1  valid line was replaced
- resp_evict_tag  out  tag_width  tag of the evicted line
- resp_error  out  1  LRU timeout, no array update
- start  out  1  LRU transaction start, one-cycle pulse
- index  out  set_index  set under update, to LRU
- found_in_cache  out  1  hit classification
- updated_cache  out  1  fill-empty classification
- replace  out  1  replace classification
- way_index  out  5  1-based way of hit/fill; 0 on replace
- update_lru  in  1  LRU done, one-cycle pulse
- block_replace  in  1  victim valid, coincident with update_lru
- replace_index  in  5  0-based victim way, valid with block_replace

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (asynchronous): all valid bits cleared; state IDLE; all outputs 0 except req_ready=1; timeout counter 0.
- States:
  - IDLE: req_ready=1. On req_valid, latch tag/index/offset and go to LOOKUP.
  - LOOKUP: one cycle. Parallel compare of the latched tag against all valid ways of the set.
    - Hit: lowest matching way wins.
    - Else fill-empty: lowest invalid way.
    - Else replace.
    - Set the classification register; go to LRU_REQ.
  - LRU_REQ: one cycle. start=1, exactly one of found_in_cache/updated_cache/replace=1, way_index = chosen way + 1 (0 on replace). Go to LRU_WAIT.
  - LRU_WAIT: index and classification outputs held stable for the whole state. Counter increments each cycle.
    - On update_lru, take the action for the classification:
      - hit: no array write.
      - fill-empty: write tag, valid=1 into the chosen way.
      - replace: sample replace_index only when block_replace=1. Capture the old tag into resp_evict_tag, set resp_evict=1, write the new tag.
      - Then go to RESP.
    - On update_lru with replace but block_replace=0: resp_error=1, no write.
    - When the counter reaches lru_timeout: resp_error=1, no write, go to RESP.
  - RESP: resp_valid=1, fields stable until resp_ready; then outputs cleared and back to IDLE.
- Timing:
  - Latency from accept to resp_valid = 3 + LRU latency cycles. Hit latency is 3 + way + 1 cycles with a standard way-serial LRU.
  - start must never reassert before update_lru or timeout. update_lru is ignored in IDLE, LOOKUP and RESP.
  - replace_index ≥ way is treated as an error: resp_error=1, no write.
- Reset mid-operation: transaction abandoned with no response. The LRU block has no reset, so rst_n must only be asserted system-wide. Stray update_lru pulses after reset are ignored.
- req_valid arriving while busy: held off by req_ready=0; no queuing.

Test Plan:
- Default params (set=512, tag_width=19). After reset, req 0x00010040 (index 4, tag 8) → start with updated_cache=1, way_index=1, index=4; after update_lru: resp_hit=0, resp_way=0, resp_evict=0.
- Repeat 0x00010040 → found_in_cache=1, way_index=1; resp_hit=1, resp_way=0; tag array unchanged.
- Fill set 4 with 0x10040, 0x12040, 0x14040, 0x16040 (ways 0-3), then 0x18040 → replace=1, way_index=0. Model returns replace_index=2 with block_replace → resp_way=2, resp_evict=1, resp_evict_tag=10. Next 0x14040 misses.
- LRU model never pulses update_lru → resp_valid with resp_error=1 exactly 64 cycles into LRU_WAIT; a follow-up hit on the set shows no array change.
- rst_n low during LRU_WAIT → outputs 0 immediately, req_ready=1 after release. Then 0x00010040 reports resp_hit=0 (valids cleared).
- Hold resp_ready=0 for 10 cycles with req_valid=1 → resp fields stable, req_ready=0 throughout, no second start pulse.
